// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer (cause priority, CSR strobes, fetch redirect, privilege mode)
module trap_ctrl #(
    parameter logic [1:0] RESET_PRIV = 2'b00
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    input  logic [31:0] addr_in,
    input  logic        illegal_inst,
    input  logic        inst_misalign,
    input  logic        ecall_inst,
    input  logic        ebreak_inst,
    input  logic        mret_inst,
    input  logic        load_misalign,
    input  logic        store_misalign,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    input  logic [31:0] mstatus_in,
    output logic        exception,
    output logic        mret,
    output logic [3:0]  mcause_out,
    output logic [31:0] mepc_out,
    output logic [31:0] mtval_out,
    output logic [1:0]  priv_mode,
    output logic        stall,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);
    typedef enum logic [1:0] {IDLE, TRAP, RET, REDIR} state_t;
    state_t      r_state;
    logic        r_exc, r_mret, r_flush, r_redir;
    logic [3:0]  r_cause;
    logic [31:0] r_mepc, r_mtval, r_rpc;
    logic [1:0]  r_priv, r_mpp;
    logic        w_m, w_ill, w_trap, w_ret, w_evt, w_unused;
    logic [3:0]  w_cause;
    logic [31:0] w_mtval;
    assign w_m      = r_priv == 2'b11;
    assign w_ill    = illegal_inst | (mret_inst & ~w_m);
    assign w_trap   = valid_in & (w_ill | inst_misalign | ecall_inst | ebreak_inst | load_misalign | store_misalign);
    assign w_ret    = valid_in & mret_inst & w_m & ~w_trap;
    assign w_evt    = w_trap | w_ret;
    assign w_cause  = w_ill ? 4'd2 : inst_misalign ? 4'd0 : ecall_inst ? (w_m ? 4'd11 : 4'd8) :
                      ebreak_inst ? 4'd3 : load_misalign ? 4'd4 : 4'd6;
    assign w_mtval  = w_cause == 4'd2 ? inst_in :
                      (w_cause == 4'd0 || w_cause == 4'd4 || w_cause == 4'd6) ? addr_in : 32'd0;
    assign w_unused = ^{mstatus_in[31:13], mstatus_in[10:0]};
    assign stall       = (r_state != IDLE) | w_evt;
    assign exception   = r_exc;
    assign mret        = r_mret;
    assign flush       = r_flush;
    assign redirect    = r_redir;
    assign redirect_pc = r_rpc;
    assign mcause_out  = r_cause;
    assign mepc_out    = r_mepc;
    assign mtval_out   = r_mtval;
    assign priv_mode   = r_priv;
    // Trap/return sequencer; strobes are registered so each lasts exactly one state
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_state <= IDLE;
            r_exc   <= 1'b0;
            r_mret  <= 1'b0;
            r_flush <= 1'b0;
            r_redir <= 1'b0;
            r_cause <= 4'd0;
            r_mepc  <= 32'd0;
            r_mtval <= 32'd0;
            r_rpc   <= 32'd0;
            r_priv  <= RESET_PRIV;
            r_mpp   <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trap) begin
                        r_cause <= w_cause;
                        r_mepc  <= pc_in;
                        r_mtval <= w_mtval;
                        r_exc   <= 1'b1;
                        r_flush <= 1'b1;
                        r_state <= TRAP;
                    end else if (w_ret) begin
                        r_mpp   <= mstatus_in[12:11];
                        r_mret  <= 1'b1;
                        r_flush <= 1'b1;
                        r_state <= RET;
                    end
                end
                TRAP: begin
                    r_priv  <= 2'b11;
                    r_rpc   <= mtvec_in & ~32'h3;
                    r_exc   <= 1'b0;
                    r_flush <= 1'b0;
                    r_redir <= 1'b1;
                    r_state <= REDIR;
                end
                RET: begin
                    r_priv  <= r_mpp;
                    r_rpc   <= mepc_in & ~32'h3;
                    r_mret  <= 1'b0;
                    r_flush <= 1'b0;
                    r_redir <= 1'b1;
                    r_state <= REDIR;
                end
                default: begin
                    r_redir <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed stimulus with a timeline model checked every cycle plus literal checkpoints
module tb_trap_ctrl;
    logic        clk = 1'b0, reset_x = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] pc_in = 0, inst_in = 0, addr_in = 0;
    logic        illegal_inst = 0, inst_misalign = 0, ecall_inst = 0, ebreak_inst = 0;
    logic        mret_inst = 0, load_misalign = 0, store_misalign = 0;
    logic [31:0] mtvec_in = 32'h801, mepc_in = 0, mstatus_in = 0;
    logic        exception, mret, stall, flush, redirect;
    logic [3:0]  mcause_out;
    logic [31:0] mepc_out, mtval_out, redirect_pc;
    logic [1:0]  priv_mode;
    int tests = 0, fails = 0;

    trap_ctrl #(.RESET_PRIV(2'b00)) dut (
        .clk(clk), .reset_x(reset_x), .valid_in(valid_in), .pc_in(pc_in), .inst_in(inst_in),
        .addr_in(addr_in), .illegal_inst(illegal_inst), .inst_misalign(inst_misalign),
        .ecall_inst(ecall_inst), .ebreak_inst(ebreak_inst), .mret_inst(mret_inst),
        .load_misalign(load_misalign), .store_misalign(store_misalign), .mtvec_in(mtvec_in),
        .mepc_in(mepc_in), .mstatus_in(mstatus_in), .exception(exception), .mret(mret),
        .mcause_out(mcause_out), .mepc_out(mepc_out), .mtval_out(mtval_out), .priv_mode(priv_mode),
        .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
        end
    endtask

    // Model: timeline of phases following an accepted event (1=trap strobe, 2=return strobe, 3=redirect)
    int          q[$];
    int          cur = 0, prev = 0, c = 0;
    logic [3:0]  m_cause = 0;
    logic [31:0] m_mepc = 0, m_mtval = 0, m_rpc = 0;
    logic [1:0]  m_priv = 2'b00, m_mpp = 2'b00;

    // -1: nothing, -2: legal mret, otherwise the trap cause
    function automatic int spec_cause(input logic [1:0] p);
        if (!valid_in) return -1;
        if (illegal_inst || (mret_inst && p != 2'b11)) return 2;
        if (inst_misalign) return 0;
        if (ecall_inst) return p == 2'b11 ? 11 : 8;
        if (ebreak_inst) return 3;
        if (load_misalign) return 4;
        if (store_misalign) return 6;
        if (mret_inst) return -2;
        return -1;
    endfunction

    always @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            q.delete();
            cur = 0; m_cause = 0; m_mepc = 0; m_mtval = 0; m_rpc = 0; m_priv = 2'b00; m_mpp = 2'b00;
        end else begin
            prev = cur;
            if (prev == 1) begin m_priv = 2'b11; m_rpc = mtvec_in & ~32'h3; end
            if (prev == 2) begin m_priv = m_mpp; m_rpc = mepc_in & ~32'h3; end
            if (prev == 0 && q.size() == 0) begin
                c = spec_cause(m_priv);
                if (c >= 0) begin
                    m_cause = 4'(c);
                    m_mepc  = pc_in;
                    m_mtval = c == 2 ? inst_in : (c == 0 || c == 4 || c == 6) ? addr_in : 32'd0;
                    q.push_back(1); q.push_back(3);
                end else if (c == -2) begin
                    m_mpp = mstatus_in[12:11];
                    q.push_back(2); q.push_back(3);
                end
            end
            cur = q.size() != 0 ? q.pop_front() : 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("exception", {31'd0, exception}, {31'd0, cur == 1});
        chk("mret", {31'd0, mret}, {31'd0, cur == 2});
        chk("flush", {31'd0, flush}, {31'd0, cur == 1 || cur == 2});
        chk("redirect", {31'd0, redirect}, {31'd0, cur == 3});
        chk("stall", {31'd0, stall}, {31'd0, cur != 0 || (cur == 0 && q.size() == 0 && spec_cause(m_priv) != -1)});
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("priv_mode", {30'd0, priv_mode}, {30'd0, m_priv});
        chk("mcause", {28'd0, mcause_out}, {28'd0, m_cause});
        chk("mepc", mepc_out, m_mepc);
        chk("mtval", mtval_out, m_mtval);
    end

    // f = {illegal, inst_misalign, ecall, ebreak, mret, load_misalign, store_misalign}
    task automatic set_in(input logic v, input logic [31:0] pc, inst, addr, input logic [6:0] f);
        valid_in = v; pc_in = pc; inst_in = inst; addr_in = addr;
        {illegal_inst, inst_misalign, ecall_inst, ebreak_inst, mret_inst, load_misalign, store_misalign} = f;
    endtask

    // Present one event for a single cycle; returns just after the sampling edge (strobe cycle)
    task automatic ev(input logic [31:0] pc, inst, addr, input logic [6:0] f);
        @(posedge clk); #1 set_in(1'b1, pc, inst, addr, f);
        @(posedge clk); #1 set_in(1'b0, 0, 0, 0, 7'd0);
    endtask

    initial begin
        #2 reset_x = 1'b0;
        @(negedge clk);
        chk("rst exception", {31'd0, exception}, 32'd0);
        chk("rst priv", {30'd0, priv_mode}, 32'd0);
        chk("rst redirect_pc", redirect_pc, 32'd0);
        @(posedge clk); #1 reset_x = 1'b1;
        // ecall from U-mode
        ev(32'h100, 32'h73, 32'h0, 7'b0010000);
        @(negedge clk);
        chk("ecallU exception", {31'd0, exception}, 32'd1);
        chk("ecallU mcause", {28'd0, mcause_out}, 32'd8);
        chk("ecallU mepc", mepc_out, 32'h100);
        chk("ecallU mtval", mtval_out, 32'h0);
        @(negedge clk);
        chk("ecallU redirect", {31'd0, redirect}, 32'd1);
        chk("ecallU rpc", redirect_pc, 32'h800);
        chk("ecallU priv", {30'd0, priv_mode}, 32'd3);
        chk("ecallU exc drop", {31'd0, exception}, 32'd0);
        // illegal outranks load misalign
        ev(32'h104, 32'hFFFFFFFF, 32'h3001, 7'b1000010);
        @(negedge clk);
        chk("ill mcause", {28'd0, mcause_out}, 32'd2);
        chk("ill mtval", mtval_out, 32'hFFFFFFFF);
        @(negedge clk);
        // legal mret back to U-mode
        mepc_in = 32'h104; mstatus_in = 32'h0;
        ev(32'h108, 32'h30200073, 32'h0, 7'b0000100);
        @(negedge clk);
        chk("mretM pulse", {31'd0, mret}, 32'd1);
        chk("mretM no exc", {31'd0, exception}, 32'd0);
        @(negedge clk);
        chk("mretM rpc", redirect_pc, 32'h104);
        chk("mretM priv", {30'd0, priv_mode}, 32'd0);
        // mret from U-mode is illegal
        ev(32'h104, 32'h30200073, 32'h0, 7'b0000100);
        @(negedge clk);
        chk("mretU exception", {31'd0, exception}, 32'd1);
        chk("mretU no mret", {31'd0, mret}, 32'd0);
        chk("mretU mcause", {28'd0, mcause_out}, 32'd2);
        chk("mretU mtval", mtval_out, 32'h30200073);
        @(negedge clk);
        // store misalign, with a second event held through TRAP and REDIR
        ev(32'h200, 32'h0, 32'h2003, 7'b0000001);
        set_in(1'b1, 32'h300, 32'h73, 32'h0, 7'b0010000);
        @(negedge clk);
        chk("st mcause", {28'd0, mcause_out}, 32'd6);
        chk("st mtval", mtval_out, 32'h2003);
        @(negedge clk);
        chk("st ignored mepc", mepc_out, 32'h200);
        chk("st ignored mcause", {28'd0, mcause_out}, 32'd6);
        set_in(1'b0, 0, 0, 0, 7'd0);
        // ecall from M-mode, ebreak over load, inst misalign, load misalign
        ev(32'h400, 32'h73, 32'h0, 7'b0010000);
        @(negedge clk); chk("ecallM mcause", {28'd0, mcause_out}, 32'd11);
        @(negedge clk);
        ev(32'h404, 32'h100073, 32'h5, 7'b0001010);
        @(negedge clk); chk("ebrk mcause", {28'd0, mcause_out}, 32'd3);
        chk("ebrk mtval", mtval_out, 32'h0);
        @(negedge clk);
        ev(32'h408, 32'h0, 32'h1002, 7'b0100001);
        @(negedge clk); chk("imis mcause", {28'd0, mcause_out}, 32'd0);
        chk("imis mtval", mtval_out, 32'h1002);
        @(negedge clk);
        ev(32'h40C, 32'h0, 32'h3005, 7'b0000011);
        @(negedge clk); chk("ld mcause", {28'd0, mcause_out}, 32'd4);
        chk("ld mtval", mtval_out, 32'h3005);
        @(negedge clk);
        // flags without valid_in do nothing
        @(posedge clk); #1 set_in(1'b0, 32'h500, 32'hFFFFFFFF, 32'h1, 7'b1111111);
        @(negedge clk); chk("novalid stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1 set_in(1'b0, 0, 0, 0, 7'd0);
        @(negedge clk); chk("novalid exc", {31'd0, exception}, 32'd0);
        chk("novalid mepc", mepc_out, 32'h40C);
        // mret in M-mode returning to M; then ecall beats a simultaneous mret
        mepc_in = 32'h207; mstatus_in = 32'h1800;
        ev(32'h600, 32'h30200073, 32'h0, 7'b0000100);
        @(negedge clk); chk("mretMM pulse", {31'd0, mret}, 32'd1);
        @(negedge clk); chk("mretMM rpc", redirect_pc, 32'h204);
        chk("mretMM priv", {30'd0, priv_mode}, 32'd3);
        ev(32'h604, 32'h73, 32'h0, 7'b0010100);
        @(negedge clk); chk("ecall+mret mcause", {28'd0, mcause_out}, 32'd11);
        chk("ecall+mret no mret", {31'd0, mret}, 32'd0);
        @(negedge clk);
        // reset asserted in the middle of TRAP
        ev(32'h700, 32'h73, 32'h0, 7'b0010000);
        #2 reset_x = 1'b0;
        #1;
        chk("rstTRAP exception", {31'd0, exception}, 32'd0);
        chk("rstTRAP flush", {31'd0, flush}, 32'd0);
        chk("rstTRAP priv", {30'd0, priv_mode}, 32'd0);
        chk("rstTRAP redirect", {31'd0, redirect}, 32'd0);
        @(posedge clk); #1 reset_x = 1'b1;
        @(negedge clk); chk("post-rst redirect", {31'd0, redirect}, 32'd0);
        chk("post-rst stall", {31'd0, stall}, 32'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
